synaptic_memory_responder: RTL
==============================

# synaptic_memory_responder

Storage-side responder for the synaptic processing unit (SPU). Holds the spike-source FIFO that the SPU drains, the weight matrix and the i_next accumulator array that the SPU reads and writes back. Also runs a clear sequencer that zeroes all i_next entries at the end of each timestep. Sits between the neuron update stage (spike producer, timestep control) and the SPU.

## Interface
- numneurons, 2: neuron count; tag range 0..numneurons-1
- numwidth, 16: data words are numwidth+1 bits, stored and returned unmodified
- tagbits, 1: tag width, clog2(numneurons)
- fifodepth, 4: spike FIFO entries, power of two
- clk  in  1  clock, all state updates on rising edge
- asyn_reset  in  1  asynchronous, active-high reset
- spike_valid  in  1  enqueue spike_tag this cycle
- spike_tag  in  tagbits  source neuron that fired
- req_deq  in  1  SPU pop request
- src_tag_out  out  tagbits  FIFO head, combinational; 0 when empty
- fifo_empty  out  1  registered-state flag, resets 1
- fifo_full  out  1  resets 0
- overflow  out  1  sticky, set on dropped enqueue; cleared only by reset
- src_tag_in  in  tagbits  SPU source tag for reads
- dst_tag_in  in  tagbits  SPU destination tag for reads and writes
- weight_out  out  numwidth+1  registered W[src][dst], resets 0
- i_next_rd  out  numwidth+1  registered I[dst], resets 0
- req_write_i_next  in  1  write i_next_wr to I[dst_tag_in]
- i_next_wr  in  numwidth+1  write data
- wgt_we  in  1  weight programming strobe
- wgt_src, wgt_dst  in  tagbits  programming address
- wgt_data  in  numwidth+1  programming data
- clear_req  in  1  start i_next clear sequence
- clearing  out  1  high while sequencer active, resets 0
- clear_done  out  1  one-cycle pulse at sequence end, resets 0
- write_dropped  out  1  sticky, set when an i_next write is ignored; reset-only clear

## Operation
- FIFO: circular buffer with head/tail pointers and count (width clog2(fifodepth)+1); pointers wrap modulo fifodepth.
- Enqueue when spike_valid and (not full, or req_deq with non-empty same cycle). Full with no deq: entry dropped, overflow set.
- Dequeue when req_deq and not empty; req_deq on empty ignored, no flag.
- Simultaneous enq+deq: both occur, count unchanged; enqueue into empty FIFO becomes visible at src_tag_out the following cycle (no bypass).
- Weights: numneurons*numneurons registers, index src*numneurons+dst; all reset to 0. wgt_we writes any state, including during clear.
- i_next array: numneurons registers, reset 0.
- Read port: every cycle weight_out <= W[src_tag_in][dst_tag_in], i_next_rd <= I[dst_tag_in]. Same-cycle write to I[dst] returns old value (read-before-write).
- Sequencer states: IDLE, CLEAR.
  - IDLE: clear_req -> CLEAR, counter <= 0, clearing <= 1.
  - CLEAR: zero I[counter], counter++; after zeroing entry numneurons-1 -> IDLE, clearing <= 0, clear_done pulses 1 cycle.
  - clear_req while in CLEAR ignored.
- req_write_i_next during CLEAR (including the entry cycle from IDLE) is dropped, write_dropped set. Outside CLEAR writes always succeed.
- Reset mid-operation: all state, pointers, arrays, flags back to reset values immediately; partially cleared array fully zeroed.

## Timing
- Read latency 1 cycle: tags presented in cycle N, data valid after edge N+1. This matches the SPU fetch->add spacing.
- Write: I[dst] updated at the edge where req_write_i_next is sampled; visible on i_next_rd one read later.
- Dequeue: head advances at the edge sampling req_deq; src_tag_out shows the next entry combinationally after that edge.
- fifo_empty/fifo_full reflect count after each edge; no combinational path from spike_valid or req_deq.
- Clear takes exactly numneurons cycles in CLEAR; clear_done is high in the cycle after the last entry is zeroed.

## Test plan
- Reset -> fifo_empty=1, fifo_full=0, overflow=0, weight_out=0, i_next_rd=0, clearing=0, all entries 0.
- Enqueue 1,0,1,0 (fifodepth 4) -> fifo_full=1; 5th enqueue dropped, overflow=1; four pops return 1,0,1,0 then fifo_empty=1.
- Full FIFO with spike_valid(tag 1) and req_deq same cycle -> head pops, tag 1 enqueued, fifo_full stays 1, overflow stays 0.
- Program W[1][0]=0x00005; src=1,dst=0 -> weight_out=0x00005 one cycle later. Write I[0]=0x00003 -> next read gives 0x00003. Write and read dst=0 in the same cycle -> old value returned.
- I[0]=7, I[1]=9; clear_req -> clearing high 2 cycles, clear_done pulse, both read 0; write during CLEAR dropped, write_dropped=1.
- Assert asyn_reset mid-CLEAR with FIFO holding 2 entries -> immediate empty FIFO, clearing=0, arrays zero, no clear_done.

Source files
------------

// File: rtl/synaptic_memory_responder_if.sv
// Bus between the neuron update stage / SPU (master) and the synaptic memory responder (slave).
// Handshake: spike_valid and req_deq are single-cycle strobes sampled on the rising edge with no ready back-pressure; fifo_full/fifo_empty only advise.
interface synaptic_memory_responder_if #(
    parameter int NUMWIDTH = 16,
    parameter int TAGBITS  = 1
);
    logic                spike_valid;
    logic [TAGBITS-1:0]  spike_tag;
    logic                req_deq;
    logic [TAGBITS-1:0]  src_tag_out;
    logic                fifo_empty;
    logic                fifo_full;
    logic                overflow;
    logic [TAGBITS-1:0]  src_tag_in;
    logic [TAGBITS-1:0]  dst_tag_in;
    logic [NUMWIDTH:0]   weight_out;
    logic [NUMWIDTH:0]   i_next_rd;
    logic                req_write_i_next;
    logic [NUMWIDTH:0]   i_next_wr;
    logic                wgt_we;
    logic [TAGBITS-1:0]  wgt_src;
    logic [TAGBITS-1:0]  wgt_dst;
    logic [NUMWIDTH:0]   wgt_data;
    logic                clear_req;
    logic                clearing;
    logic                clear_done;
    logic                write_dropped;

    modport master (
        output spike_valid, spike_tag, req_deq, src_tag_in, dst_tag_in,
               req_write_i_next, i_next_wr, wgt_we, wgt_src, wgt_dst, wgt_data, clear_req,
        input  src_tag_out, fifo_empty, fifo_full, overflow, weight_out, i_next_rd,
               clearing, clear_done, write_dropped
    );

    modport slave (
        input  spike_valid, spike_tag, req_deq, src_tag_in, dst_tag_in,
               req_write_i_next, i_next_wr, wgt_we, wgt_src, wgt_dst, wgt_data, clear_req,
        output src_tag_out, fifo_empty, fifo_full, overflow, weight_out, i_next_rd,
               clearing, clear_done, write_dropped
    );
endinterface

// File: rtl/synaptic_memory_responder.sv
// Storage side of the SPU: spike-source FIFO, weight matrix, i_next accumulators
// with a registered read port, and the end-of-timestep i_next clear sequencer.
module synaptic_memory_responder #(
    parameter int NUMNEURONS = 2,
    parameter int NUMWIDTH   = 16,
    parameter int TAGBITS    = 1,
    parameter int FIFODEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          asyn_reset,
    synaptic_memory_responder_if.slave    bus,
    output logic                          dbg_state_o
);
    localparam int PW = $clog2(FIFODEPTH);
    localparam int CW = PW + 1;
    localparam logic [TAGBITS-1:0] LAST_ENTRY = TAGBITS'(NUMNEURONS - 1);

    typedef logic [NUMWIDTH:0] data_t;
    typedef enum logic {IDLE, CLEAR} seq_state_t;

    // ---------------- spike FIFO ----------------
    logic [TAGBITS-1:0] fifo_mem_q [FIFODEPTH];
    logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               empty, full, do_enq, do_deq;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFODEPTH));

    always_comb begin
        do_deq     = bus.req_deq && !empty;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        do_enq     = bus.spike_valid && (!full || do_deq);
        head_d     = do_deq ? head_q + 1'b1 : head_q;
        tail_d     = do_enq ? tail_q + 1'b1 : tail_q;
        count_d    = count_q;
        if (do_enq && !do_deq) begin
            count_d = count_q + 1'b1;
        end else if (!do_enq && do_deq) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = overflow_q || (bus.spike_valid && !do_enq);
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFODEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (do_enq) begin
                fifo_mem_q[tail_q] <= bus.spike_tag;
            end
        end
    end

    assign bus.src_tag_out = empty ? '0 : fifo_mem_q[head_q];
    assign bus.fifo_empty  = empty;
    assign bus.fifo_full   = full;
    assign bus.overflow    = overflow_q;

    // ---------------- clear sequencer ----------------
    seq_state_t         state_q, state_d;
    logic [TAGBITS-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ENTRY) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.clearing   = (state_q == CLEAR);
    assign bus.clear_done = done_q;
    assign dbg_state_o    = (state_q == CLEAR);

    // ---------------- weight / i_next arrays ----------------
    data_t w_q     [NUMNEURONS][NUMNEURONS];
    data_t inext_q [NUMNEURONS];
    data_t weight_q, inext_rd_q;
    logic  clear_window, write_ok;
    logic  write_dropped_q, write_dropped_d;

    // The IDLE cycle that accepts clear_req already belongs to the clear window.
    assign clear_window    = (state_q == CLEAR) || bus.clear_req;
    assign write_ok        = bus.req_write_i_next && !clear_window;
    assign write_dropped_d = write_dropped_q || (bus.req_write_i_next && clear_window);

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            for (int s = 0; s < NUMNEURONS; s++) begin
                inext_q[s] <= '0;
                for (int d = 0; d < NUMNEURONS; d++) begin
                    w_q[s][d] <= '0;
                end
            end
            weight_q        <= '0;
            inext_rd_q      <= '0;
            write_dropped_q <= 1'b0;
        end else begin
            if (bus.wgt_we) begin
                w_q[bus.wgt_src][bus.wgt_dst] <= bus.wgt_data;
            end
            if (state_q == CLEAR) begin
                inext_q[cnt_q] <= '0;
            end else if (write_ok) begin
                inext_q[bus.dst_tag_in] <= bus.i_next_wr;
            end
            weight_q        <= w_q[bus.src_tag_in][bus.dst_tag_in];
            inext_rd_q      <= inext_q[bus.dst_tag_in];
            write_dropped_q <= write_dropped_d;
        end
    end

    assign bus.weight_out    = weight_q;
    assign bus.i_next_rd     = inext_rd_q;
    assign bus.write_dropped = write_dropped_q;
endmodule
